// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx shared definitions: register map, STATUS layout, FSM states.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package mmio_uart_tx_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;
`endif

    function automatic logic [31:0] pack_status(
        input logic ovf,
        input logic busy,
        input logic empty,
        input logic full
    );
        logic [31:0] s;
        s = '0;
        s[STAT_OVF]   = ovf;
        s[STAT_BUSY]  = busy;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL]  = full;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx bus: strobes, word offset and data from the I/O decode.
// master = data-memory stage, slave = UART transmitter.
interface mmio_uart_tx_if;

    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (
        output wr_en,
        output rd_en,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  addr,
        input  din,
        output dout
    );

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with one extra pointer bit to tell full from empty.
// A pop in the same cycle frees a slot, so a push while full still lands.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // pointer update; reset discards contents by equalising pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage needs no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit before STOP).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    mmio_uart_tx_if.slave   bus,
    output logic            tx,
    output logic            irq_empty
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    tx_state_t     state_nx;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_nx;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nx;
    logic [7:0]    shift;
    logic [7:0]    shift_nx;
    logic          tx_nx;
    logic          bit_end;
    logic          busy;
    logic          overflow;
    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    head;
    logic          unused_din;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    assign unused_din = &{1'b0, bus.din[31:8]};
    assign push_req   = bus.wr_en && (bus.addr == UART_DATA);
    assign busy       = (state != S_IDLE);
    assign bit_end    = (baud == BAUD_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (bus.din[7:0]),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // serialiser state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            tx      <= tx_nx;
        end
    end

`ifdef UART_TX_PARITY_EN
    // even parity latched with the byte as it leaves the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      parity <= 1'b0;
        else if (pop) parity <= ^head;
    end
`endif

    // next state, baud/bit counters and the line level for the next cycle
    always_comb begin
        state_nx   = state;
        baud_nx    = baud;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        pop        = 1'b0;
        if (state != S_IDLE) baud_nx = bit_end ? '0 : baud + 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_nx = head;
                    baud_nx  = '0;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_idx_nx = '0;
                    state_nx   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end else begin
                        shift_nx   = {1'b0, shift[7:1]};
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_nx = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        case (state_nx)
            S_START:  tx_nx = 1'b0;
            S_DATA:   tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_nx = parity;
`endif
            default:  tx_nx = 1'b1;
        endcase
    end

    // sticky overflow: set on a dropped byte, cleared by CTRL bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (bus.wr_en && bus.addr == UART_CTRL && bus.din[0]) begin
            overflow <= 1'b0;
        end
    end

    // registered read port; only STATUS returns data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout <= '0;
        end else if (bus.rd_en) begin
            unique case (1'b1)
                (bus.addr == UART_STATUS):
                    bus.dout <= pack_status(overflow, busy,
                                            fifo_empty, fifo_full);
                default: bus.dout <= '0;
            endcase
        end
    end

    // empty interrupt: nothing queued and nothing on the wire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_empty <= 1'b1;
        else     irq_empty <= (state == S_IDLE) && fifo_empty;
    end

endmodule
